// File: rtl/tm_feedback_issuer_pkg.sv
// Shared types and constants for the Tsetlin-machine feedback issuer: feedback type codes,
// FSM state encoding and the 16-bit Galois LFSR definition.
package tm_pkg;

  localparam logic FB_TYPE_I  = 1'b0;
  localparam logic FB_TYPE_II = 1'b1;

  localparam int          LFSR_W    = 16;
  // Galois tap mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/tm_lfsr16.sv
// 16-bit Galois LFSR that advances once per step; reusable by other feedback blocks.
module tm_lfsr16
  import tm_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (rst)       state <= SEED;
    else if (step) state <= lfsr_next(state);
  end

endmodule

// File: rtl/tm_feedback_issuer.sv
// Walks all clauses after a start pulse and streams per-clause feedback decisions (enable + type).
// Optional macro TM_FB_COUNT_EN adds the fb_count output (handshakes with fb_en=1 in the pass).
module tm_feedback_issuer
  import tm_pkg::*;
#(
  parameter int          T_WIDTH     = 8,
  parameter int          NUM_CLAUSES = 16,
  parameter int          CIDX_W      = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [T_WIDTH:0]   T,
  input  logic [T_WIDTH:0]   q,
  input  logic [T_WIDTH-1:0] d,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CIDX_W-1:0]  out_cidx,
  output logic               out_fb_en,
  output logic               out_fb_type,
  output logic               busy,
  output logic               done
`ifdef TM_FB_COUNT_EN
  ,
  output logic [CIDX_W:0]    fb_count
`endif
);

  localparam int PW = 2 * T_WIDTH + 1;

  state_t             state;
  logic [T_WIDTH:0]   t_lat;
  logic [T_WIDTH:0]   q_lat;
  logic [T_WIDTH-1:0] d_lat;
  logic [15:0]        lfsr_q;
  logic [15:0]        lfsr_n;
  logic               hs;
  logic               last;

  // Full-width product so r*T never wraps; d/T is the resulting enable probability.
  function automatic logic fb_decide(input logic [15:0] s, input logic [T_WIDTH:0] t,
                                     input logic [T_WIDTH-1:0] dv);
    logic [PW-1:0] prod;
    logic [PW-1:0] thr;
    prod = {{(T_WIDTH+1){1'b0}}, s[T_WIDTH-1:0]} * {{T_WIDTH{1'b0}}, t};
    thr  = {1'b0, dv, {T_WIDTH{1'b0}}};
    if (t == '0)             return 1'b0;
    else if ({1'b0, dv} >= t) return 1'b1;
    else                     return prod < thr;
  endfunction

  // Even index = positive clause; q selects which polarity gets Type I.
  function automatic logic fb_type_of(input logic idx_odd, input logic q_nz);
    if (q_nz) return idx_odd ? FB_TYPE_II : FB_TYPE_I;
    else      return idx_odd ? FB_TYPE_I  : FB_TYPE_II;
  endfunction

  assign hs     = out_valid && out_ready && (state == S_ISSUE);
  assign last   = (out_cidx == CIDX_W'(NUM_CLAUSES - 1));
  assign lfsr_n = lfsr_next(lfsr_q);

  tm_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (hs),
    .state (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      out_valid   <= 1'b0;
      out_cidx    <= '0;
      out_fb_en   <= 1'b0;
      out_fb_type <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            t_lat       <= T;
            q_lat       <= q;
            d_lat       <= d;
            out_cidx    <= '0;
            out_valid   <= 1'b1;
            busy        <= 1'b1;
            out_fb_en   <= fb_decide(lfsr_q, T, d);
            out_fb_type <= fb_type_of(1'b0, |q);
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (hs) begin
            if (last) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= S_FINISH;
            end else begin
              // Next decision uses the post-step LFSR value so there is no bubble.
              out_cidx    <= out_cidx + CIDX_W'(1);
              out_fb_en   <= fb_decide(lfsr_n, t_lat, d_lat);
              out_fb_type <= fb_type_of(~out_cidx[0], |q_lat);
            end
          end
        end
        S_FINISH: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TM_FB_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)                           fb_count <= '0;
    else if (state == S_IDLE && start) fb_count <= '0;
    else if (hs && out_fb_en)          fb_count <= fb_count + (CIDX_W+1)'(1);
  end
`endif

endmodule

// File: tb/tb_tm_feedback_issuer.sv
// Directed, table-driven bench for tm_feedback_issuer with an independent LFSR/decision model.
module tb_tm_feedback_issuer;

  localparam int TW = 8;
  localparam int N  = 16;
  localparam int CW = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [TW:0]   t_in;
  logic [TW:0]   q_in;
  logic [TW-1:0] d_in;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_cidx;
  logic          out_fb_en;
  logic          out_fb_type;
  logic          busy;
  logic          done;
`ifdef TM_FB_COUNT_EN
  logic [CW:0]   fb_count;
`endif

  tm_feedback_issuer #(.T_WIDTH(TW), .NUM_CLAUSES(N), .CIDX_W(CW), .LFSR_SEED(SEED)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .T           (t_in),
    .q           (q_in),
    .d           (d_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_cidx    (out_cidx),
    .out_fb_en   (out_fb_en),
    .out_fb_type (out_fb_type),
    .busy        (busy),
    .done        (done)
`ifdef TM_FB_COUNT_EN
    ,
    .fb_count    (fb_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [15:0] m_lfsr;
  int stat_hits;

  typedef struct {
    string name;
    int    t;
    int    q;
    int    d;
    int    stall_at;
    int    stall_len;
    int    bstart_at;
    int    rst_at;
    int    exp_all;   // -1: no blanket expectation, else every fb_en must equal this
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] m_next(input logic [15:0] s);
    logic [15:0] n;
    n = {1'b0, s[15:1]};
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic int m_fb(input logic [15:0] s, input int t, input int dv);
    int r;
    r = int'(s) % 256;
    if (t == 0) return 0;
    if (dv >= t) return 1;
    return (r * t < dv * 256) ? 1 : 0;
  endfunction

  function automatic int m_type(input int idx, input int qv);
    if (qv != 0) return idx % 2;
    return 1 - (idx % 2);
  endfunction

  task automatic run_pass(input vec_t v);
    int exp_cnt;
    int ef;
    logic [CW-1:0] s_cidx;
    logic s_en;
    logic s_ty;
    exp_cnt = 0;
    t_in = (TW+1)'(v.t);
    q_in = (TW+1)'(v.q);
    d_in = TW'(v.d);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({v.name, "_busy_rise"}, int'(busy), 1);
    for (int i = 0; i < N; i++) begin
      ef = m_fb(m_lfsr, v.t, v.d);
      check({v.name, "_valid"}, int'(out_valid), 1);
      check({v.name, "_cidx"}, int'(out_cidx), i);
      check({v.name, "_fb_en"}, int'(out_fb_en), ef);
      check({v.name, "_fb_type"}, int'(out_fb_type), m_type(i, v.q));
      if (v.exp_all >= 0) check({v.name, "_fb_en_all"}, int'(out_fb_en), v.exp_all);
      if (v.name == "stat") stat_hits += int'(out_fb_en);
      if (i == v.rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check({v.name, "_rst_valid"}, int'(out_valid), 0);
        check({v.name, "_rst_busy"}, int'(busy), 0);
        check({v.name, "_rst_done"}, int'(done), 0);
        check({v.name, "_rst_cidx"}, int'(out_cidx), 0);
        m_lfsr = SEED;
        tick();
        check({v.name, "_rst_no_done"}, int'(done), 0);
        return;
      end
      if (i == v.stall_at) begin
        s_cidx = out_cidx;
        s_en = out_fb_en;
        s_ty = out_fb_type;
        out_ready = 1'b0;
        for (int k = 0; k < v.stall_len; k++) begin
          tick();
          check({v.name, "_stall_valid"}, int'(out_valid), 1);
          check({v.name, "_stall_cidx"}, int'(out_cidx), int'(s_cidx));
          check({v.name, "_stall_fb_en"}, int'(out_fb_en), int'(s_en));
          check({v.name, "_stall_fb_type"}, int'(out_fb_type), int'(s_ty));
        end
        out_ready = 1'b1;
      end
      if (i == v.bstart_at) begin
        start = 1'b1;
        d_in = TW'(v.d) ^ 8'h55;
      end
      exp_cnt += ef;
      tick();
      start = 1'b0;
      d_in = TW'(v.d);
      m_lfsr = m_next(m_lfsr);
    end
    check({v.name, "_end_valid"}, int'(out_valid), 0);
    check({v.name, "_done"}, int'(done), 1);
    check({v.name, "_end_busy"}, int'(busy), 0);
`ifdef TM_FB_COUNT_EN
    check({v.name, "_fb_count"}, int'(fb_count), exp_cnt);
`endif
    tick();
    check({v.name, "_done_drop"}, int'(done), 0);
    check({v.name, "_idle_valid"}, int'(out_valid), 0);
`ifdef TM_FB_COUNT_EN
    check({v.name, "_fb_count_hold"}, int'(fb_count), exp_cnt);
`endif
  endtask

  initial begin
    vec_t sv;
    vecs[0] = '{"d0",       36, 1,   0, -1, 0, -1, -1,  0};
    vecs[1] = '{"dT",       36, 0,  36, -1, 0, -1, -1,  1};
    vecs[2] = '{"T0",        0, 1,   5, -1, 0, -1, -1,  0};
    vecs[3] = '{"dgtT",     20, 1, 200, -1, 0, -1, -1,  1};
    vecs[4] = '{"bp",       36, 1,   9,  3, 5, -1, -1, -1};
    vecs[5] = '{"bstart",   36, 1,   9, -1, 0,  5, -1, -1};
    vecs[6] = '{"rstmid",   36, 0,   9, -1, 0, -1,  7, -1};
    vecs[7] = '{"afterrst", 36, 1,  18, -1, 0, -1, -1, -1};
    vecs[8] = '{"maxT",    511, 1, 255, -1, 0, -1, -1, -1};

    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    t_in = '0;
    q_in = '0;
    d_in = '0;
    stat_hits = 0;
    m_lfsr = SEED;
    tick();
    tick();
    rst = 1'b0;
    check("reset_valid", int'(out_valid), 0);
    check("reset_cidx", int'(out_cidx), 0);
    check("reset_fb_en", int'(out_fb_en), 0);
    check("reset_fb_type", int'(out_fb_type), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
`ifdef TM_FB_COUNT_EN
    check("reset_fb_count", int'(fb_count), 0);
`endif
    tick();
    check("idle_no_start_valid", int'(out_valid), 0);

    for (int p = 0; p < 9; p++) run_pass(vecs[p]);

    sv = '{"stat", 36, 1, 9, -1, 0, -1, -1, -1};
    for (int p = 0; p < 64; p++) run_pass(sv);
    tests++;
    if (stat_hits < 205 || stat_hits > 307) begin
      fails++;
      $display("FAIL stat_rate: got %0d of 1024 fb_en, expected 205..307", stat_hits);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
